// File: rtl/dual_bank_mem_pkg.sv
// Shared definitions for the banked dual-port memory: default geometry,
// bank-select width and the request/port-id types used by the top level.
package dual_mem_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int ADDR_W_DEF    = 6;
  localparam int NUM_BANKS_DEF = 4;
  localparam int CNT_W_DEF     = 16;
  localparam int BANK_W        = $clog2(NUM_BANKS_DEF);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_e;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } port_req_t;

endpackage

// File: rtl/dual_bank_mem_if.sv
// One memory port: request handshake plus the 1-cycle read response.
interface dual_bank_mem_if
  import dual_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              valid;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output valid, we, addr, wdata, input ready, rvalid, rdata);
  modport slave  (input valid, we, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/dual_bank_sp.sv
// Single-port synchronous RAM bank; read data registered, valid one cycle
// after the enabled read. Contents are never reset.
module dual_bank_sp #(
  parameter int DATA_W = 8,
  parameter int ROW_W  = 4
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ROW_W-1:0]  row_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**ROW_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[row_i] <= wdata_i;
      else      rdata_q      <= mem_q[row_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/dual_bank_mem.sv
// Banked dual-port memory: round-robin arbitration of same-bank A/B requests,
// per-bank steering, response routing and a saturating conflict counter.
module dual_bank_mem
  import dual_mem_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NUM_BANKS = NUM_BANKS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  dual_bank_mem_if.slave   a_port,
  dual_bank_mem_if.slave   b_port,
  output logic [CNT_W-1:0] conflict_cnt
);
  localparam int BSEL_W = $clog2(NUM_BANKS);
  localparam int ROW_W  = (ADDR_W > BSEL_W) ? (ADDR_W - BSEL_W) : 1;

  logic [BSEL_W-1:0] a_bank, b_bank;
  logic [ROW_W-1:0]  a_row, b_row;
  logic              conflict, a_ready, b_ready;

  port_id_e          prio_q, prio_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NUM_BANKS-1:0] a_hit, b_hit, bank_en, bank_we;
  logic [NUM_BANKS-1:0] rd_vld_d, rd_vld_q;
  port_id_e             rd_port_d [NUM_BANKS];
  port_id_e             rd_port_q [NUM_BANKS];
  logic [ROW_W-1:0]     bank_row   [NUM_BANKS];
  logic [DATA_W-1:0]    bank_wdata [NUM_BANKS];
  logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];

  logic              a_rvalid, b_rvalid;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic [DATA_W-1:0] a_hold_q, b_hold_q;

  assign a_bank = a_port.addr[BSEL_W-1:0];
  assign b_bank = b_port.addr[BSEL_W-1:0];
  assign a_row  = ROW_W'(a_port.addr >> BSEL_W);
  assign b_row  = ROW_W'(b_port.addr >> BSEL_W);

  // Arbitration: the prio port wins a same-bank clash, loser gets prio next.
  assign conflict = a_port.valid && b_port.valid && (a_bank == b_bank);
  assign a_ready  = a_port.valid && (!conflict || (prio_q == PORT_A));
  assign b_ready  = b_port.valid && (!conflict || (prio_q == PORT_B));
  assign prio_d   = conflict ? ((prio_q == PORT_A) ? PORT_B : PORT_A) : prio_q;
  assign cnt_d    = (conflict && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

  assign a_port.ready = a_ready;
  assign b_port.ready = b_ready;
  assign conflict_cnt = cnt_q;

  // Accesses during reset are suppressed so a write on a reset edge is dropped.
  always_comb begin
    for (int k = 0; k < NUM_BANKS; k++) begin
      a_hit[k]      = a_ready && (a_bank == BSEL_W'(k));
      b_hit[k]      = b_ready && (b_bank == BSEL_W'(k));
      bank_en[k]    = (a_hit[k] || b_hit[k]) && !rst;
      bank_we[k]    = b_hit[k] ? b_port.we    : a_port.we;
      bank_row[k]   = b_hit[k] ? b_row        : a_row;
      bank_wdata[k] = b_hit[k] ? b_port.wdata : a_port.wdata;
      rd_port_d[k]  = b_hit[k] ? PORT_B       : PORT_A;
      rd_vld_d[k]   = bank_en[k] && !bank_we[k];
    end
  end

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    dual_bank_sp #(
      .DATA_W (DATA_W),
      .ROW_W  (ROW_W)
    ) u_bank (
      .clk     (clk),
      .en_i    (bank_en[k]),
      .we_i    (bank_we[k]),
      .row_i   (bank_row[k]),
      .wdata_i (bank_wdata[k]),
      .rdata_o (bank_rdata[k])
    );
  end

  // Response routing: a bank with a read in flight returns it to its owner.
  always_comb begin
    a_rvalid = 1'b0;
    b_rvalid = 1'b0;
    a_rdata  = a_hold_q;
    b_rdata  = b_hold_q;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (rd_vld_q[k] && (rd_port_q[k] == PORT_A)) begin
        a_rvalid = 1'b1;
        a_rdata  = bank_rdata[k];
      end
      if (rd_vld_q[k] && (rd_port_q[k] == PORT_B)) begin
        b_rvalid = 1'b1;
        b_rdata  = bank_rdata[k];
      end
    end
  end

  assign a_port.rvalid = a_rvalid;
  assign a_port.rdata  = a_rdata;
  assign b_port.rvalid = b_rvalid;
  assign b_port.rdata  = b_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q   <= PORT_A;
      cnt_q    <= '0;
      rd_vld_q <= '0;
      a_hold_q <= '0;
      b_hold_q <= '0;
      for (int k = 0; k < NUM_BANKS; k++) rd_port_q[k] <= PORT_A;
    end else begin
      prio_q   <= prio_d;
      cnt_q    <= cnt_d;
      rd_vld_q <= rd_vld_d;
      a_hold_q <= a_rdata;
      b_hold_q <= b_rdata;
      for (int k = 0; k < NUM_BANKS; k++) rd_port_q[k] <= rd_port_d[k];
    end
  end
endmodule

// File: doc/dual_bank_mem.md
Name: dual_bank_mem

Overview:
- Banked dual-port memory. It is the responder that the port-A and port-B drivers of the dual-port environment talk to.
- The address space is interleaved across NUM_BANKS single-port banks, selected by the low address bits.
- Requests on ports A and B to different banks proceed in parallel.
- Requests on A and B to the same bank in the same cycle are serialized by a round-robin arbiter using a valid/ready handshake.
- Read data returns with a fixed latency of 1 cycle.

Parameters:
DATA_W, 8, data width per word
ADDR_W, 6, word address width (depth = 2**ADDR_W)
NUM_BANKS, 4, bank count; power of 2, at least 2, at most 2**ADDR_W
CNT_W, 16, width of the saturating conflict counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-high
a_valid  in  1  port A request present
a_we  in  1  port A write (1) / read (0)
a_addr  in  ADDR_W  port A word address
a_wdata  in  DATA_W  port A write data
a_ready  out  1  port A request accepted this cycle
a_rvalid  out  1  port A read data valid
a_rdata  out  DATA_W  port A read data
b_valid, b_we, b_addr, b_wdata, b_ready, b_rvalid, b_rdata: same as port A, for port B
conflict_cnt  out  CNT_W  number of cycles with a same-bank conflict, saturating

Behaviour:
- Bank mapping: bank = addr[log2(NUM_BANKS)-1:0]; row = addr[ADDR_W-1:log2(NUM_BANKS)].
- Conflict: a_valid && b_valid && bank(a_addr)==bank(b_addr). The address need not be equal.
- a_ready and b_ready are combinational:
  - No conflict: x_ready = x_valid.
  - Conflict: only the port selected by prio gets ready=1.
- Priority pointer prio: 0 = A, 1 = B. Reset value 0.
  - On a conflict cycle, prio is set to the losing port.
  - Non-conflict cycles leave prio unchanged.
- Handshake: a transfer occurs when valid && ready. A stalled requester holds valid, we, addr and wdata stable until ready.
- Accepted write: the bank row is updated at the clock edge. Write data is never returned on rvalid.
- Accepted read:
  - x_rvalid=1 in the next cycle, with x_rdata = the bank row contents at the acceptance edge.
  - Read-before-write cannot occur within a bank, because a bank serves one access per cycle.
- x_rdata holds its last value when x_rvalid=0.
- Back-to-back reads on the same port are accepted every cycle. Throughput is 1 per port per cycle without conflicts.
- conflict_cnt:
  - Increments by 1 on every conflict cycle, whether read or write.
  - Saturates at 2**CNT_W-1.
- Reset values: a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, conflict_cnt=0, prio=0.
- Memory array contents are not reset. Reading an unwritten row is undefined, so the bench writes before reading.
- Reset mid-operation: rst asserted asynchronously clears rvalid, rdata, prio and conflict_cnt immediately. A pending read response is dropped. A write accepted on an edge where rst is high is not performed.
- Both ports writing the same address: the writes are serialized by the arbiter. The final value is from the later-granted port.

Decomposition:
- Shared package (dual_mem_pkg) holds:
  - DATA_W, ADDR_W, NUM_BANKS defaults.
  - BANK_W = $clog2(NUM_BANKS).
  - Typedefs for port request struct (valid, we, addr, wdata) and port-id enum {PORT_A, PORT_B}.
- One sub-module, dual_bank_sp:
  - Single-port synchronous RAM of depth 2**ADDR_W/NUM_BANKS.
  - Inputs en, we, row, wdata; output rdata registered, 1-cycle latency.
  - Instantiated NUM_BANKS times via generate.
  - The top holds the arbiter, bank muxing, response routing (registered port-id per bank) and the counter.

Test Plan:
- Write A addr 0x05 data 0xAA, then read B addr 0x05 → b_ready=1 on request cycle; b_rvalid=1 next cycle; b_rdata=0xAA.
- Simultaneous A read 0x04 (bank 0) and B read 0x01 (bank 1), both preloaded 0x11/0x22 → both ready=1; both rvalid next cycle; rdata 0x11/0x22; conflict_cnt stays 0.
- Simultaneous A write 0x08=0x33 and B write 0x0C=0x44 (both bank 0), held 2 cycles from reset → cycle 1 a_ready=1, b_ready=0; cycle 2 b_ready=1; conflict_cnt=1; prio=1 afterward.
- Both ports write addr 0x10, A=0x55, B=0x66, same cycle from reset → A first, B second; subsequent read of 0x10 returns 0x66.
- A read accepted, rst pulsed for a fraction of the next cycle → a_rvalid=0, a_rdata=0 immediately; conflict_cnt=0.
- With CNT_W=2, force 5 conflict cycles → conflict_cnt reads 1, 2, 3, 3, 3.
